// File: rtl/bus_dev_fifo_if.sv
// Device/arbiter-side signal bundle for one bus_dev_fifo endpoint.
// The slave modport is the endpoint; the master modport is the device/arbiter side.
interface bus_dev_fifo_if #(
  parameter int pckg_sz = 32,
  parameter int depth   = 16
);
  localparam int CW = $clog2(depth) + 1;

  logic               wr_en;
  logic [pckg_sz-1:0] wr_data;
  logic               tx_full;
  logic [CW-1:0]      tx_count;
  logic               tx_ovf;
  logic               pndng;
  logic [pckg_sz-1:0] D_pop;
  logic               pop;
  logic               push;
  logic [pckg_sz-1:0] D_push;
  logic               rd_en;
  logic [pckg_sz-1:0] rd_data;
  logic               rx_empty;
  logic [CW-1:0]      rx_count;
  logic [7:0]         rx_drop_cnt;

  modport master (
    output wr_en, wr_data, pop, push, D_push, rd_en,
    input  tx_full, tx_count, tx_ovf, pndng, D_pop,
           rd_data, rx_empty, rx_count, rx_drop_cnt
  );

  modport slave (
    input  wr_en, wr_data, pop, push, D_push, rd_en,
    output tx_full, tx_count, tx_ovf, pndng, D_pop,
           rd_data, rx_empty, rx_count, rx_drop_cnt
  );
endinterface

// File: rtl/bus_dev_fifo.sv
// Per-device endpoint: TX FIFO feeding the bus arbiter, and an ID-filtered RX FIFO
// receiving from it. Both FIFOs are first-word-fall-through circular buffers.
module bus_dev_fifo #(
  parameter int         pckg_sz   = 32,
  parameter int         depth     = 16,
  parameter logic [7:0] id        = 8'd0,
  parameter logic [7:0] broadcast = 8'hFF
) (
  input logic           clk,
  input logic           reset,
  bus_dev_fifo_if.slave bus
);
  localparam int            AW       = $clog2(depth);
  localparam int            CW       = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(depth);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [CW-1:0] next_cnt(input logic [CW-1:0] c,
                                             input logic wr, input logic rd);
    logic [CW-1:0] n;
    n = c;
    if (wr && !rd)      n = c + CW'(1);
    else if (!wr && rd) n = c - CW'(1);
    return n;
  endfunction

  // ---------------- TX path ----------------
  logic [pckg_sz-1:0] r_tx_mem [depth];
  logic [AW-1:0]      r_tx_wp;
  logic [AW-1:0]      r_tx_rp;
  logic [CW-1:0]      r_tx_cnt;
  logic               r_tx_ovf;

  logic w_tx_full;
  logic w_tx_pop;
  logic w_tx_wr;

  assign w_tx_full = (r_tx_cnt == FULL_CNT);
  assign w_tx_pop  = bus.pop && (r_tx_cnt != '0);
  // A pop in the same cycle frees the slot the write needs.
  assign w_tx_wr   = bus.wr_en && (!w_tx_full || w_tx_pop);

  always_ff @(posedge clk) begin
    if (reset && w_tx_wr) r_tx_mem[r_tx_wp] <= bus.wr_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_tx_wp  <= '0;
      r_tx_rp  <= '0;
      r_tx_cnt <= '0;
      r_tx_ovf <= 1'b0;
    end else begin
      if (w_tx_wr)               r_tx_wp  <= r_tx_wp + AW'(1);
      if (w_tx_pop)              r_tx_rp  <= r_tx_rp + AW'(1);
      r_tx_cnt <= next_cnt(r_tx_cnt, w_tx_wr, w_tx_pop);
      if (bus.wr_en && !w_tx_wr) r_tx_ovf <= 1'b1;
    end
  end

  assign bus.tx_full  = w_tx_full;
  assign bus.tx_count = r_tx_cnt;
  assign bus.tx_ovf   = r_tx_ovf;
  assign bus.pndng    = (r_tx_cnt != '0);
  assign bus.D_pop    = r_tx_mem[r_tx_rp];

  // ---------------- RX path ----------------
  logic [pckg_sz-1:0] r_rx_mem [depth];
  logic [AW-1:0]      r_rx_wp;
  logic [AW-1:0]      r_rx_rp;
  logic [CW-1:0]      r_rx_cnt;
  logic [7:0]         r_rx_drop;

  logic [7:0] w_dst;
  logic       w_match;
  logic       w_rx_full;
  logic       w_rx_rd;
  logic       w_rx_wr;
  logic       w_rx_drop;

  assign w_dst     = bus.D_push[pckg_sz-1 -: 8];
  assign w_match   = bus.push && ((w_dst == id) || (w_dst == broadcast));
  assign w_rx_full = (r_rx_cnt == FULL_CNT);
  assign w_rx_rd   = bus.rd_en && (r_rx_cnt != '0);
  assign w_rx_wr   = w_match && (!w_rx_full || w_rx_rd);
  assign w_rx_drop = w_match && !w_rx_wr;

  always_ff @(posedge clk) begin
    if (reset && w_rx_wr) r_rx_mem[r_rx_wp] <= bus.D_push;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rx_wp   <= '0;
      r_rx_rp   <= '0;
      r_rx_cnt  <= '0;
      r_rx_drop <= '0;
    end else begin
      if (w_rx_wr)   r_rx_wp   <= r_rx_wp + AW'(1);
      if (w_rx_rd)   r_rx_rp   <= r_rx_rp + AW'(1);
      r_rx_cnt <= next_cnt(r_rx_cnt, w_rx_wr, w_rx_rd);
      if (w_rx_drop) r_rx_drop <= sat_inc8(r_rx_drop);
    end
  end

  assign bus.rd_data     = r_rx_mem[r_rx_rp];
  assign bus.rx_empty    = (r_rx_cnt == '0);
  assign bus.rx_count    = r_rx_cnt;
  assign bus.rx_drop_cnt = r_rx_drop;
endmodule

// File: tb/tb_bus_dev_fifo.sv
// Directed self-checking bench for bus_dev_fifo (pckg_sz=32, depth=16, id=3).
module tb_bus_dev_fifo;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  bus_dev_fifo_if #(.pckg_sz(32), .depth(16)) bus ();

  bus_dev_fifo #(
    .pckg_sz(32), .depth(16), .id(8'd3), .broadcast(8'hFF)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.pop     = 1'b0;
    bus.push    = 1'b0;
    bus.D_push  = '0;
    bus.rd_en   = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b0;
    idle_inputs();
    tick();
    tick();
    reset = 1'b1;

    // reset state
    check("rst_pndng",    32'(bus.pndng),       32'd0);
    check("rst_tx_full",  32'(bus.tx_full),     32'd0);
    check("rst_tx_count", 32'(bus.tx_count),    32'd0);
    check("rst_tx_ovf",   32'(bus.tx_ovf),      32'd0);
    check("rst_rx_empty", 32'(bus.rx_empty),    32'd1);
    check("rst_rx_count", 32'(bus.rx_count),    32'd0);
    check("rst_rx_drop",  32'(bus.rx_drop_cnt), 32'd0);

    // basic TX
    bus.wr_en = 1'b1; bus.wr_data = 32'h01AA_0001;
    tick();
    check("tx1_pndng", 32'(bus.pndng), 32'd1);
    check("tx1_dpop",  bus.D_pop,      32'h01AA_0001);
    bus.wr_data = 32'h02BB_0002;
    tick();
    bus.wr_en = 1'b0;
    check("tx2_count", 32'(bus.tx_count), 32'd2);
    bus.pop = 1'b1;
    tick();
    check("pop1_dpop",  bus.D_pop,         32'h02BB_0002);
    check("pop1_count", 32'(bus.tx_count), 32'd1);
    tick();
    bus.pop = 1'b0;
    check("pop2_pndng", 32'(bus.pndng),    32'd0);
    check("pop2_count", 32'(bus.tx_count), 32'd0);
    bus.pop = 1'b1;
    tick();
    bus.pop = 1'b0;
    check("pop_empty_count", 32'(bus.tx_count), 32'd0);

    // TX full / overflow, pointers start at 2 so the fill wraps
    bus.wr_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.wr_data = 32'h1000_0000 + 32'(i);
      tick();
    end
    bus.wr_en = 1'b0;
    check("fill_full",  32'(bus.tx_full),  32'd1);
    check("fill_count", 32'(bus.tx_count), 32'd16);
    check("fill_ovf",   32'(bus.tx_ovf),   32'd0);
    bus.wr_en = 1'b1; bus.wr_data = 32'hDEAD_BEEF;
    tick();
    bus.wr_en = 1'b0;
    check("ovf_set",   32'(bus.tx_ovf),   32'd1);
    check("ovf_count", 32'(bus.tx_count), 32'd16);
    check("ovf_head",  bus.D_pop,         32'h1000_0000);
    bus.wr_en = 1'b1; bus.wr_data = 32'h1000_0010; bus.pop = 1'b1;
    tick();
    bus.wr_en = 1'b0;
    check("wrpop_count", 32'(bus.tx_count), 32'd16);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain_tx%0d", i), bus.D_pop, 32'h1000_0001 + 32'(i));
      tick();
    end
    bus.pop = 1'b0;
    check("drain_tx_pndng", 32'(bus.pndng),  32'd0);
    check("drain_tx_ovf",   32'(bus.tx_ovf), 32'd1);

    // RX filter
    bus.push = 1'b1;
    bus.D_push = 32'h0300_0001; tick();
    bus.D_push = 32'h0500_0002; tick();
    bus.D_push = 32'hFF00_0003; tick();
    bus.push = 1'b0;
    check("filt_count", 32'(bus.rx_count), 32'd2);
    check("filt_rd0",   bus.rd_data,       32'h0300_0001);
    bus.rd_en = 1'b1;
    tick();
    check("filt_rd1", bus.rd_data, 32'hFF00_0003);
    tick();
    bus.rd_en = 1'b0;
    check("filt_empty", 32'(bus.rx_empty),    32'd1);
    check("filt_drop",  32'(bus.rx_drop_cnt), 32'd0);

    // push + rd_en on empty RX: read ignored, packet stored
    bus.push = 1'b1; bus.D_push = 32'h0300_0100; bus.rd_en = 1'b1;
    tick();
    bus.push = 1'b0; bus.rd_en = 1'b0;
    check("pe_count", 32'(bus.rx_count), 32'd1);
    check("pe_data",  bus.rd_data,       32'h0300_0100);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    check("pe_drain", 32'(bus.rx_empty), 32'd1);

    // fill RX, then push + rd_en on full
    bus.push = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.D_push = 32'h0300_0200 + 32'(i);
      tick();
    end
    bus.push = 1'b0;
    check("rxfull_count", 32'(bus.rx_count), 32'd16);
    bus.push = 1'b1; bus.D_push = 32'h0300_0210; bus.rd_en = 1'b1;
    tick();
    bus.push = 1'b0; bus.rd_en = 1'b0;
    check("pf_count", 32'(bus.rx_count),    32'd16);
    check("pf_drop",  32'(bus.rx_drop_cnt), 32'd0);

    // drops on full RX
    bus.push = 1'b1; bus.D_push = 32'h0300_1000;
    tick();
    check("drop_one", 32'(bus.rx_drop_cnt), 32'd1);
    bus.D_push = 32'h0500_1000;
    tick();
    check("drop_nomatch", 32'(bus.rx_drop_cnt), 32'd1);
    for (int i = 1; i < 300; i++) begin
      bus.D_push = 32'h0300_1000 + 32'(i);
      tick();
    end
    bus.push = 1'b0;
    check("drop_sat",   32'(bus.rx_drop_cnt), 32'd255);
    check("drop_count", 32'(bus.rx_count),    32'd16);
    bus.rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain_rx%0d", i), bus.rd_data, 32'h0300_0201 + 32'(i));
      tick();
    end
    bus.rd_en = 1'b0;
    check("drain_rx_empty", 32'(bus.rx_empty), 32'd1);

    // reset mid-traffic
    bus.wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.wr_data = 32'h2000_0000 + 32'(i);
      tick();
    end
    bus.wr_en = 1'b0;
    check("pre_rst_count", 32'(bus.tx_count), 32'd5);
    bus.pop = 1'b1; bus.wr_en = 1'b1; bus.wr_data = 32'h2000_00FF;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    idle_inputs();
    check("mid_rst_pndng", 32'(bus.pndng),       32'd0);
    check("mid_rst_count", 32'(bus.tx_count),    32'd0);
    check("mid_rst_ovf",   32'(bus.tx_ovf),      32'd0);
    check("mid_rst_drop",  32'(bus.rx_drop_cnt), 32'd0);
    bus.wr_en = 1'b1; bus.wr_data = 32'hABCD_0001;
    tick();
    bus.wr_en = 1'b0;
    check("post_rst_pndng", 32'(bus.pndng),    32'd1);
    check("post_rst_head",  bus.D_pop,         32'hABCD_0001);
    check("post_rst_count", 32'(bus.tx_count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/bus_dev_fifo.md
# bus_dev_fifo

Per-device endpoint that sits between a device and the `bs_gnrtr_n_rbtr` bus arbiter. It holds the device's outgoing packets in a TX FIFO and presents them to the arbiter via the `pndng`/`pop`/`D_pop` handshake. It also accepts packets the arbiter delivers via `push`/`D_push`, filters them by destination ID, and queues them in an RX FIFO for the device to read. One instance per device; `drvrs` instances sit in front of the arbiter.

## Interface
Parameters:
- `pckg_sz`, 32: packet width; bits [pckg_sz-1:pckg_sz-8] hold the destination ID.
- `depth`, 16: entries per FIFO; power of two, ≥ 2.
- `id`, 0: this device's 8-bit ID.
- `broadcast`, 8'hFF: destination ID accepted by every device.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-low (0 = reset).
- `wr_en`  in  1: device writes `wr_data` into the TX FIFO.
- `wr_data`  in  pckg_sz: outgoing packet.
- `tx_full`  out  1: TX FIFO holds `depth` entries.
- `tx_count`  out  $clog2(depth)+1: TX occupancy.
- `tx_ovf`  out  1: sticky flag; a write was rejected.
- `pndng`  out  1: TX FIFO non-empty (to arbiter).
- `D_pop`  out  pckg_sz: TX head packet (to arbiter).
- `pop`  in  1: arbiter consumes the TX head.
- `push`  in  1: arbiter delivers `D_push`.
- `D_push`  in  pckg_sz: incoming packet.
- `rd_en`  in  1: device consumes the RX head.
- `rd_data`  out  pckg_sz: RX head packet.
- `rx_empty`  out  1: RX FIFO empty.
- `rx_count`  out  $clog2(depth)+1: RX occupancy.
- `rx_drop_cnt`  out  8: count of matching packets dropped because the RX FIFO was full; saturates at 255.

## Operation
- Both FIFOs are first-word-fall-through circular buffers.
  - Read and write pointers are $clog2(depth) bits wide and wrap from depth-1 to 0.
  - Occupancy is kept in a separate counter.
- TX FIFO:
  - `pndng` = (tx_count != 0).
  - `D_pop` = TX head whenever `pndng`=1; don't-care when `pndng`=0.
  - `pop` with `pndng`=1 advances the head. `pop` with `pndng`=0 is ignored.
  - `wr_en` with space, or with `pop` accepted in the same cycle, stores `wr_data`.
  - `wr_en` when full with no pop: data discarded, `tx_ovf` set to 1. `tx_ovf` clears only on reset.
- RX filter: a packet is a match when `D_push[pckg_sz-1:pckg_sz-8]` equals `id` or `broadcast`.
  - Non-matching pushes are ignored silently and are not counted.
- RX FIFO:
  - A matching `push` stores `D_push` if space is available, or if `rd_en` is accepted in the same cycle.
  - Otherwise the packet is discarded and `rx_drop_cnt` increments, saturating at 255.
  - `rd_data` = RX head whenever `rx_empty`=0.
  - `rd_en` with `rx_empty`=1 is ignored.
- Simultaneous write and read on the same FIFO:
  - Count unchanged.
  - Both pointers advance.
  - Data order is preserved.
- Reset (`reset`=0 at a clock edge), including mid-traffic:
  - Pointers, counts, `tx_ovf` and `rx_drop_cnt` go to 0.
  - Stored contents are abandoned.
  - All inputs are ignored during that edge.

## Timing
- Reset values: `pndng`=0, `tx_full`=0, `tx_count`=0, `tx_ovf`=0, `rx_empty`=1, `rx_count`=0, `rx_drop_cnt`=0.
- `D_pop` and `rd_data` are unspecified after reset until the first write.
- Write-to-visible latency is 1 cycle.
  - A `wr_en` at edge N gives `pndng`=1 and a valid `D_pop` after edge N.
  - The same applies to `push` → `rx_empty`/`rd_data`.
- `pop` or `rd_en` sampled at edge N: the next head appears, or the flag updates, after edge N.
- Status outputs (`pndng`, `tx_full`, counts, `rx_empty`) are registered or derived only from registered state.
  - They have no combinational path from `pop`, `push`, `wr_en` or `rd_en`.
- `D_pop` and `rd_data` are a combinational read of the storage array at the head pointer.
- The arbiter may assert `pop` on any cycle where `pndng`=1. Back-to-back pops drain one entry per cycle.

## Test plan
- **Reset and basic TX:** after reset, write 0x01AA_0001 and then 0x02BB_0002.
  - `pndng`=1 after the first edge; `D_pop`=0x01AA_0001.
  - `pop` → `D_pop`=0x02BB_0002.
  - Second `pop` → `pndng`=0, `tx_count`=0.
- **TX full/overflow** (depth=16): 16 writes → `tx_full`=1, `tx_ovf`=0.
  - 17th write alone → discarded, `tx_ovf`=1.
  - 17th write with simultaneous `pop` → accepted, `tx_count` stays 16.
  - Drain order is the write order, across pointer wrap.
- **RX filter** (id=3): push 0x03000001, then 0x05000002, then 0xFF000003.
  - `rx_count`=2.
  - Reads return 0x03000001, then 0xFF000003.
  - `rx_drop_cnt`=0.
- **RX full drop:** fill RX with 16 matching packets, then push 300 more matching packets with `rd_en`=0.
  - `rx_drop_cnt`=255, saturated.
  - `rx_count`=16; contents are the first 16 packets.
- **Simultaneous read/write on empty/full:** RX empty with `push`+`rd_en` in one cycle → `rd_en` ignored, packet stored, `rx_count`=1.
  - With RX full, the same pair → `rx_count`=16, no drop.
- **Reset mid-traffic:** with TX holding 5 entries and `pop` active, drive `reset`=0 for 1 cycle.
  - Next cycle: `pndng`=0, `tx_count`=0, `tx_ovf`=0, `rx_drop_cnt`=0.
  - A following write appears as the new head.
